pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage pipeline. It drives the write-enable and bubble controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Sources of stalls and flushes:
- load-use hazards detected in ID;
- multi-cycle data-memory accesses in MEM, via a req/ack handshake;
- taken branches resolved in ID.

It also keeps a stall-cycle performance counter and flags a hung data memory.

Parameters:
MEM_TIMEOUT, 64, max cycles in MEM_WAIT before ERROR (>=2)
CNT_W, 16, width of stall_cnt_o

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  reset, asynchronous, active-low
id_rs_i  input  5  rs field of instruction in ID
id_rt_i  input  5  rt field of instruction in ID
id_useRt_i  input  1  ID instruction reads rt as a source
ex_memRead_i  input  1  instruction in EX is a load
ex_rt_i  input  5  destination (rt) of the load in EX
branch_taken_i  input  1  branch in ID resolved taken
mem_op_i  input  1  MEM stage holds a valid load/store
mem_ack_i  input  1  data memory completes the access this cycle
dmem_req_o  output  1  request to data memory
pc_write_o  output  1  PC write enable
ifid_write_o  output  1  IF/ID write enable
ifid_flush_o  output  1  IF/ID clears to NOP on next edge
idex_bubble_o  output  1  ID/EX captures zeroed control (bubble)
exmem_write_o  output  1  EX/MEM write enable
memwb_bubble_o  output  1  MEM/WB captures memToReg=0, regWrite=0
err_o  output  1  sticky memory-timeout error
stall_cnt_o  output  CNT_W  saturating count of stalled cycles

Behaviour:
- State register values are RUN, MEM_WAIT and ERROR. Timeout counter tcnt is ceil(log2(MEM_TIMEOUT)) bits.
- While rst_i=0, asynchronously and regardless of clk_i:
  - state=RUN, tcnt=0, stall_cnt_o=0, err_o=0;
  - dmem_req_o=0, pc_write_o=0, ifid_write_o=0, exmem_write_o=0, ifid_flush_o=0;
  - idex_bubble_o=1, memwb_bubble_o=1.
- Outputs are combinational from state and inputs. Priority order: ERROR > memory stall > load-use > branch flush.
- load_use = ex_memRead_i & (ex_rt_i!=0) & ((ex_rt_i==id_rs_i) | (id_useRt_i & ex_rt_i==id_rt_i)).
- RUN, default: all write enables 1, bubbles 0, flush 0, dmem_req_o=mem_op_i.
- RUN, mem_op_i=1 and mem_ack_i=1: single-cycle access, no stall.
- RUN, mem_op_i=1 and mem_ack_i=0:
  - pc_write_o=ifid_write_o=exmem_write_o=0, idex_bubble_o=0, memwb_bubble_o=1;
  - next state MEM_WAIT, tcnt=1.
  - ID/EX holds, not bubbled: its write enable is tied to pc_write_o by the integrator.
- RUN, no memory stall, load_use=1:
  - pc_write_o=0, ifid_write_o=0, idex_bubble_o=1, ifid_flush_o=0 (branch flush suppressed; the branch re-evaluates next cycle);
  - exmem_write_o=1, memwb_bubble_o=0. Exactly one bubble per load-use pair.
- RUN, no memory stall, no load_use, branch_taken_i=1: ifid_flush_o=1, all enables 1.
- MEM_WAIT:
  - dmem_req_o=1, held continuously; EX/MEM is frozen, so address and data stay stable.
  - mem_ack_i=0: same freeze as the RUN miss case; tcnt++. When tcnt==MEM_TIMEOUT-1 with no ack, next state is ERROR.
  - mem_ack_i=1: in that same cycle, enables are released per RUN rules (load-use and branch evaluated normally) and memwb_bubble_o=0, so MEM/WB captures the data. Next state RUN, tcnt=0.
  - An ack arriving in the timeout cycle wins; go to RUN.
- ERROR: everything frozen, bubbles 1, dmem_req_o=0, err_o=1. Only reset exits.
- stall_cnt_o increments on every clock edge where pc_write_o=0 outside reset, ERROR included. It saturates at all ones with no wrap.
- Reset asserted mid MEM_WAIT drops dmem_req_o immediately. After release, the first cycle is RUN.

Test Plan:
1. Reset release, mem_op_i=0, no hazards → pc_write_o=1, all bubbles/flush 0, stall_cnt_o=0, err_o=0.
2. ex_memRead_i=1, ex_rt_i=5, id_rs_i=5, branch_taken_i=1 → one cycle of pc_write_o=0, idex_bubble_o=1, ifid_flush_o=0; next cycle (ex_memRead_i=0) ifid_flush_o=1; stall_cnt_o=1. Repeat with ex_rt_i=0 → no stall.
3. mem_op_i=1, mem_ack_i asserted after 3 cycles → dmem_req_o high 4 cycles; pc/ifid/exmem enables low 3 cycles; memwb_bubble_o=1 for 3 cycles then 0 on the ack cycle; stall_cnt_o=3.
4. mem_op_i=1 with mem_ack_i=1 the same cycle → no stall, stays RUN.
5. MEM_TIMEOUT=4, no ack → ERROR entered after 4 stalled cycles, err_o=1 sticky, dmem_req_o=0. Ack at tcnt=3 instead → RUN, err_o=0.
6. CNT_W=3, 10 forced stall cycles → stall_cnt_o saturates at 7. Assert rst_i=0 mid MEM_WAIT → dmem_req_o=0 asynchronously, counter 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - hazard unit inputs from the pipeline and stall/flush controls back to it
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs_i;
  logic [4:0]       id_rt_i;
  logic             id_useRt_i;
  logic             ex_memRead_i;
  logic [4:0]       ex_rt_i;
  logic             branch_taken_i;
  logic             mem_op_i;
  logic             mem_ack_i;
  logic             dmem_req_o;
  logic             pc_write_o;
  logic             ifid_write_o;
  logic             ifid_flush_o;
  logic             idex_bubble_o;
  logic             exmem_write_o;
  logic             memwb_bubble_o;
  logic             err_o;
  logic [CNT_W-1:0] stall_cnt_o;

  modport master (
    output id_rs_i, id_rt_i, id_useRt_i, ex_memRead_i, ex_rt_i,
           branch_taken_i, mem_op_i, mem_ack_i,
    input  dmem_req_o, pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o,
           exmem_write_o, memwb_bubble_o, err_o, stall_cnt_o
  );

  modport slave (
    input  id_rs_i, id_rt_i, id_useRt_i, ex_memRead_i, ex_rt_i,
           branch_taken_i, mem_op_i, mem_ack_i,
    output dmem_req_o, pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o,
           exmem_write_o, memwb_bubble_o, err_o, stall_cnt_o
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush controller for the 5-stage pipeline
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  pipeline_hazard_ctrl_if.slave hz
);
  localparam int            TW        = $clog2(MEM_TIMEOUT);
  localparam logic [TW-1:0] TCNT_LAST = TW'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic load_use;
  logic mem_stall;
  logic dmem_req;
  logic pc_write;
  logic ifid_write;
  logic ifid_flush;
  logic idex_bubble;
  logic exmem_write;
  logic memwb_bubble;

  assign load_use = hz.ex_memRead_i && (hz.ex_rt_i != 5'd0) &&
                    ((hz.ex_rt_i == hz.id_rs_i) ||
                     (hz.id_useRt_i && (hz.ex_rt_i == hz.id_rt_i)));

  always_comb begin
    state_d   = state_q;
    tcnt_d    = tcnt_q;
    mem_stall = 1'b0;
    dmem_req  = 1'b0;
    unique case (state_q)
      RUN: begin
        dmem_req = hz.mem_op_i;
        if (hz.mem_op_i && !hz.mem_ack_i) begin
          mem_stall = 1'b1;
          state_d   = MEM_WAIT;
          tcnt_d    = TW'(1);
        end
      end
      MEM_WAIT: begin
        dmem_req = 1'b1;
        // An ack in the timeout cycle still completes the access.
        if (!hz.mem_ack_i) begin
          mem_stall = 1'b1;
          tcnt_d    = tcnt_q + 1'b1;
          if (tcnt_q == TCNT_LAST) begin
            state_d = ERROR;
          end
        end else begin
          state_d = RUN;
          tcnt_d  = '0;
        end
      end
      default: begin
        dmem_req = 1'b0;
      end
    endcase
  end

  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_write  = 1'b1;
    memwb_bubble = 1'b0;
    if (state_q == ERROR) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      exmem_write  = 1'b0;
      idex_bubble  = 1'b1;
      memwb_bubble = 1'b1;
    end else if (mem_stall) begin
      // ID/EX holds with the PC rather than bubbling.
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      exmem_write  = 1'b0;
      memwb_bubble = 1'b1;
    end else if (load_use) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end else if (hz.branch_taken_i) begin
      ifid_flush = 1'b1;
    end

    stall_cnt_d = stall_cnt_q;
    if (!pc_write && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= RUN;
      tcnt_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      tcnt_q      <= tcnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Reset forces a safe frozen/bubbled pipeline without waiting for a clock.
  assign hz.dmem_req_o     = rst_i & dmem_req;
  assign hz.pc_write_o     = rst_i & pc_write;
  assign hz.ifid_write_o   = rst_i & ifid_write;
  assign hz.ifid_flush_o   = rst_i & ifid_flush;
  assign hz.exmem_write_o  = rst_i & exmem_write;
  assign hz.idex_bubble_o  = ~rst_i | idex_bubble;
  assign hz.memwb_bubble_o = ~rst_i | memwb_bubble;
  assign hz.err_o          = rst_i & (state_q == ERROR);
  assign hz.stall_cnt_o    = stall_cnt_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - vectors, corner sequences and random stimulus against a reference model
module tb_pipeline_hazard_ctrl;
  localparam int TO_A = 64;
  localparam int TO_B = 4;
  localparam int CW_A = 16;
  localparam int CW_B = 3;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic [4:0] s_rs = '0, s_rt = '0, s_exrt = '0;
  logic s_usert = 1'b0, s_memread = 1'b0, s_br = 1'b0, s_memop = 1'b0, s_ack = 1'b0;

  pipeline_hazard_ctrl_if #(.CNT_W(CW_A)) ifa ();
  pipeline_hazard_ctrl_if #(.CNT_W(CW_B)) ifb ();

  assign ifa.id_rs_i = s_rs;           assign ifb.id_rs_i = s_rs;
  assign ifa.id_rt_i = s_rt;           assign ifb.id_rt_i = s_rt;
  assign ifa.id_useRt_i = s_usert;     assign ifb.id_useRt_i = s_usert;
  assign ifa.ex_memRead_i = s_memread; assign ifb.ex_memRead_i = s_memread;
  assign ifa.ex_rt_i = s_exrt;         assign ifb.ex_rt_i = s_exrt;
  assign ifa.branch_taken_i = s_br;    assign ifb.branch_taken_i = s_br;
  assign ifa.mem_op_i = s_memop;       assign ifb.mem_op_i = s_memop;
  assign ifa.mem_ack_i = s_ack;        assign ifb.mem_ack_i = s_ack;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO_A), .CNT_W(CW_A)) dut_a (
    .clk_i(clk_i), .rst_i(rst_i), .hz(ifa.slave));
  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO_B), .CNT_W(CW_B)) dut_b (
    .clk_i(clk_i), .rst_i(rst_i), .hz(ifb.slave));

  int checks = 0;
  int errors = 0;

  // Model: mode 0=running, 1=waiting on memory, 2=hung; waited = stalled memory cycles so far.
  int m_mode[2]  = '{0, 0};
  int m_wait[2]  = '{0, 0};
  int m_stall[2] = '{0, 0};
  int m_to[2]    = '{TO_A, TO_B};
  int m_max[2]   = '{(1 << CW_A) - 1, (1 << CW_B) - 1};
  logic [7:0] m_exp[2];

  // Packed order: req, pc_we, ifid_we, flush, idex_bubble, exmem_we, memwb_bubble, err
  function automatic logic [7:0] dut_pack(input int k);
    if (k == 0)
      return {ifa.dmem_req_o, ifa.pc_write_o, ifa.ifid_write_o, ifa.ifid_flush_o,
              ifa.idex_bubble_o, ifa.exmem_write_o, ifa.memwb_bubble_o, ifa.err_o};
    return {ifb.dmem_req_o, ifb.pc_write_o, ifb.ifid_write_o, ifb.ifid_flush_o,
            ifb.idex_bubble_o, ifb.exmem_write_o, ifb.memwb_bubble_o, ifb.err_o};
  endfunction

  function automatic int dut_cnt(input int k);
    return (k == 0) ? int'(ifa.stall_cnt_o) : int'(ifb.stall_cnt_o);
  endfunction

  task automatic chk(input string name, input int k, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s[dut%0d]: got 0x%0h expected 0x%0h at %0t", name, k, act, exp, $time);
    end
  endtask

  function automatic bit hazard_lu();
    return s_memread && (s_exrt != 0) && ((s_exrt == s_rs) || (s_usert && (s_exrt == s_rt)));
  endfunction

  function automatic bit mem_blocked(input int k);
    return !s_ack && ((m_mode[k] == 1) || s_memop);
  endfunction

  task automatic model_eval(input int k);
    logic req;
    req = (m_mode[k] == 1) || s_memop;
    if (!rst_i)                m_exp[k] = 8'b0000_1010;
    else if (m_mode[k] == 2)   m_exp[k] = 8'b0000_1011;
    else if (mem_blocked(k))   m_exp[k] = {req, 7'b000_0010};
    else if (hazard_lu())      m_exp[k] = {req, 7'b000_1100};
    else if (s_br)             m_exp[k] = {req, 7'b111_0100};
    else                       m_exp[k] = {req, 7'b110_0100};
  endtask

  task automatic model_advance(input int k);
    if (!rst_i) begin
      m_mode[k] = 0; m_wait[k] = 0; m_stall[k] = 0;
    end else begin
      if (!m_exp[k][6] && m_stall[k] < m_max[k]) m_stall[k]++;
      if (m_mode[k] != 2) begin
        if (mem_blocked(k)) begin
          m_wait[k]++;
          m_mode[k] = (m_wait[k] >= m_to[k]) ? 2 : 1;
        end else begin
          m_mode[k] = 0; m_wait[k] = 0;
        end
      end
    end
  endtask

  // Inputs are set by the caller 2 time units after a rising edge; outputs checked 1 unit later.
  task automatic do_cycle(input int tk, input logic [7:0] texp);
    #1;
    for (int k = 0; k < 2; k++) begin
      model_eval(k);
      chk("outputs", k, int'(dut_pack(k)), int'(m_exp[k]));
      chk("stall_cnt", k, dut_cnt(k), rst_i ? m_stall[k] : 0);
    end
    if (tk >= 0) chk("vector", tk, int'(dut_pack(tk)), int'(texp));
    @(posedge clk_i);
    for (int k = 0; k < 2; k++) model_advance(k);
    #2;
  endtask

  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic usert,
                        input logic memread, input logic [4:0] exrt, input logic br,
                        input logic memop, input logic ack);
    s_rs = rs; s_rt = rt; s_usert = usert; s_memread = memread;
    s_exrt = exrt; s_br = br; s_memop = memop; s_ack = ack;
  endtask

  typedef struct {
    logic [4:0] rs, rt, exrt;
    logic usert, memread, br, memop, ack;
    logic [7:0] exp;
  } vec_t;

  vec_t tab[$];

  function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic usert,
                              input logic memread, input logic [4:0] exrt, input logic br,
                              input logic memop, input logic ack, input logic [7:0] exp);
    vec_t v;
    v.rs = rs; v.rt = rt; v.usert = usert; v.memread = memread; v.exrt = exrt;
    v.br = br; v.memop = memop; v.ack = ack; v.exp = exp;
    return v;
  endfunction

  initial begin
    //           rs  rt  useRt rd  exrt br memop ack expected
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 8'b0110_0100));  // idle
    tab.push_back(mk(5, 1, 0, 1, 5, 1, 0, 0, 8'b0000_1100));  // load-use beats branch
    tab.push_back(mk(5, 1, 0, 0, 5, 1, 0, 0, 8'b0111_0100));  // branch re-evaluated
    tab.push_back(mk(0, 0, 0, 1, 0, 1, 0, 0, 8'b0111_0100));  // r0 never hazards
    tab.push_back(mk(3, 7, 1, 1, 7, 0, 0, 0, 8'b0000_1100));  // rt source match
    tab.push_back(mk(3, 7, 0, 1, 7, 0, 0, 0, 8'b0110_0100));  // rt not a source
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 8'b1110_0100));  // single-cycle access
    tab.push_back(mk(2, 0, 0, 1, 2, 0, 1, 1, 8'b1000_1100));  // access plus load-use
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 8'b0110_0100));  // stray ack
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 8'b1000_0010));  // miss
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 8'b1000_0010));  // waiting
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 8'b1000_0010));  // waiting, req held
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 8'b1110_0100));  // ack releases
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 8'b0110_0100));  // back to run

    #2;
    do_cycle(0, 8'b0000_1010);
    do_cycle(1, 8'b0000_1010);
    rst_i = 1'b1;

    foreach (tab[i]) begin
      set_in(tab[i].rs, tab[i].rt, tab[i].usert, tab[i].memread, tab[i].exrt,
             tab[i].br, tab[i].memop, tab[i].ack);
      do_cycle(0, tab[i].exp);
    end
    chk("cnt_after_vectors", 0, dut_cnt(0), 6);
    chk("cnt_after_vectors", 1, dut_cnt(1), 6);

    // Timeout on the short-timeout instance; counter saturates at 7 there.
    for (int i = 0; i < 4; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 1, 0);
      do_cycle(1, 8'b1000_0010);
    end
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 1);
      do_cycle(1, 8'b0000_1011);
    end
    chk("cnt_saturated", 1, dut_cnt(1), 7);
    chk("cnt_wide", 0, dut_cnt(0), 10);

    rst_i = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    do_cycle(1, 8'b0000_1010);
    rst_i = 1'b1;

    // Asynchronous reset in the middle of a memory wait.
    set_in(0, 0, 0, 0, 0, 0, 1, 0);
    do_cycle(0, 8'b1000_0010);
    do_cycle(1, 8'b1000_0010);
    #2;
    rst_i = 1'b0;
    #1;
    chk("async_req", 0, int'(ifa.dmem_req_o), 0);
    chk("async_req", 1, int'(ifb.dmem_req_o), 0);
    chk("async_cnt", 0, dut_cnt(0), 0);
    @(posedge clk_i);
    for (int k = 0; k < 2; k++) model_advance(k);
    #2;
    rst_i = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    do_cycle(0, 8'b0110_0100);

    // Ack arriving in the last allowed cycle wins over timeout.
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 1, 0);
      do_cycle(1, 8'b1000_0010);
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 1);
    do_cycle(1, 8'b1110_0100);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    do_cycle(1, 8'b0110_0100);

    for (int n = 0; n < 3000; n++) begin
      rst_i = ($urandom_range(99) != 0);
      set_in(5'($urandom_range(3)), 5'($urandom_range(3)), 1'($urandom_range(1)),
             1'($urandom_range(1)), 5'($urandom_range(3)), ($urandom_range(9) < 3),
             ($urandom_range(9) < 3), ($urandom_range(9) < 6));
      do_cycle(-1, 8'h00);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
